lane_frame_serializer: RTL and testbench

//   Consumer side of the three-lane P1-wide bundle produced by module1 (out1/out2/out3).

---
 rtl/lane_frame_pkg.sv | 34 +++
 rtl/lane_frame_serializer_if.sv | 31 +++
 rtl/lane_frame_serializer.sv | 115 +++++++++++
 tb/tb_lane_frame_serializer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lane_frame_pkg.sv
// Shared types for the lane frame serializer: beat tags, FSM states, defaults.
package lane_frame_pkg;

    localparam int unsigned DefLaneWidth  = 4;
    localparam int unsigned DefCountWidth = 5;

    typedef enum logic [1:0] {
        TagLane0 = 2'd0,
        TagLane1 = 2'd1,
        TagLane2 = 2'd2,
        TagCsum  = 2'd3
    } lane_tag_e;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StSend0   = 3'd1,
        StSend1   = 3'd2,
        StSend2   = 3'd3,
        StSendSum = 3'd4
    } ser_state_e;

    // Tag carried by the beat presented in a given state; IDLE reads as lane 0.
    function automatic lane_tag_e beat_tag(input ser_state_e st);
        lane_tag_e tag;
        case (st)
            StSend1:   tag = TagLane1;
            StSend2:   tag = TagLane2;
            StSendSum: tag = TagCsum;
            default:   tag = TagLane0;
        endcase
        return tag;
    endfunction

endpackage

// File: rtl/lane_frame_serializer_if.sv
// Bundle input and serial stream output of the lane frame serializer.
// master: bundle producer / stream consumer. slave: the serializer itself.
interface lane_frame_serializer_if
    import lane_frame_pkg::*;
#(
    parameter int unsigned P1 = DefLaneWidth
) ();

    logic          s_valid;
    logic          s_ready;
    logic [P1-1:0] s_lane0;
    logic [P1-1:0] s_lane1;
    logic [P1-1:0] s_lane2;

    logic          m_valid;
    logic          m_ready;
    logic [P1-1:0] m_data;
    lane_tag_e     m_tag;
    logic          m_last;

    modport master (
        output s_valid, s_lane0, s_lane1, s_lane2, m_ready,
        input  s_ready, m_valid, m_data, m_tag, m_last
    );

    modport slave (
        input  s_valid, s_lane0, s_lane1, s_lane2, m_ready,
        output s_ready, m_valid, m_data, m_tag, m_last
    );

endinterface

// File: rtl/lane_frame_serializer.sv
// Serializes one three-lane bundle per handshake into four tagged beats:
// lane0, lane1, lane2, checksum. A new bundle may be taken on the checksum
// handshake so back-to-back frames stream with no bubble.
module lane_frame_serializer
    import lane_frame_pkg::*;
#(
    parameter int unsigned P1 = DefLaneWidth,
    parameter int unsigned P2 = DefCountWidth
) (
    input  logic                    clk,
    input  logic                    rst,
    lane_frame_serializer_if.slave  bus,
    output logic [P2-1:0]           frame_count
);

    typedef struct packed {
        logic [P1-1:0] lane2;
        logic [P1-1:0] lane1;
        logic [P1-1:0] lane0;
    } lane_bundle_t;

    ser_state_e    state_q, state_d;
    lane_bundle_t  cap_q, cap_d;
    logic [P1-1:0] sum_q, sum_d;
    logic [P2-1:0] frame_count_q, frame_count_d;
    logic          m_valid_q, m_valid_d;
    logic [P1-1:0] m_data_q, m_data_d;
    lane_tag_e     m_tag_q, m_tag_d;
    logic          m_last_q, m_last_d;

    logic s_ready;
    logic accept;
    logic sum_done;

    // Bundle may be taken when idle or while the checksum beat is leaving.
    always_comb begin
        s_ready  = (state_q == StIdle) || ((state_q == StSendSum) && bus.m_ready);
        accept   = bus.s_valid && s_ready;
        sum_done = (state_q == StSendSum) && bus.m_ready;
    end

    // Next state, capture and frame counter.
    always_comb begin
        state_d       = state_q;
        cap_d         = cap_q;
        sum_d         = sum_q;
        frame_count_d = frame_count_q;

        case (state_q)
            StIdle:    if (accept)       state_d = StSend0;
            StSend0:   if (bus.m_ready)  state_d = StSend1;
            StSend1:   if (bus.m_ready)  state_d = StSend2;
            StSend2:   if (bus.m_ready)  state_d = StSendSum;
            StSendSum: if (bus.m_ready)  state_d = accept ? StSend0 : StIdle;
            default:                     state_d = StIdle;
        endcase

        if (accept) begin
            cap_d.lane0 = bus.s_lane0;
            cap_d.lane1 = bus.s_lane1;
            cap_d.lane2 = bus.s_lane2;
            // Checksum wraps at lane width; carries are dropped on purpose.
            sum_d       = bus.s_lane0 + bus.s_lane1 + bus.s_lane2;
        end

        if (sum_done) begin
            frame_count_d = frame_count_q + {{(P2-1){1'b0}}, 1'b1};
        end
    end

    // Beat mux on the upcoming state so outputs come straight from flops.
    always_comb begin
        m_valid_d = (state_d != StIdle);
        m_tag_d   = beat_tag(state_d);
        m_last_d  = (state_d == StSendSum);
        case (state_d)
            StSend0:   m_data_d = cap_d.lane0;
            StSend1:   m_data_d = cap_d.lane1;
            StSend2:   m_data_d = cap_d.lane2;
            StSendSum: m_data_d = sum_d;
            default:   m_data_d = '0;
        endcase
    end

    // FSM, capture register and registered stream outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            cap_q         <= '0;
            sum_q         <= '0;
            frame_count_q <= '0;
            m_valid_q     <= 1'b0;
            m_data_q      <= '0;
            m_tag_q       <= TagLane0;
            m_last_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cap_q         <= cap_d;
            sum_q         <= sum_d;
            frame_count_q <= frame_count_d;
            m_valid_q     <= m_valid_d;
            m_data_q      <= m_data_d;
            m_tag_q       <= m_tag_d;
            m_last_q      <= m_last_d;
        end
    end

    assign bus.s_ready = s_ready;
    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    assign bus.m_tag   = m_tag_q;
    assign bus.m_last  = m_last_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_lane_frame_serializer.sv
// Directed bench for lane_frame_serializer with a beat-queue reference model.
module tb_lane_frame_serializer;

    localparam int unsigned P1 = 4;
    localparam int unsigned P2 = 5;

    typedef struct {
        int data;
        int tag;
        int last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [P2-1:0] frame_count;

    lane_frame_serializer_if #(.P1(P1)) bus ();

    lane_frame_serializer #(.P1(P1), .P2(P2)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    beat_t exp_q[$];
    int    exp_fc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each accepted bundle queues four beats; the head beat is what
    // must be on the stream, and the bundle side is ready only when the
    // queue is empty or its last beat is leaving this cycle.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_fc = 0;
        end else begin
            check("s_ready", {31'd0, bus.s_ready},
                  {31'd0, (exp_q.size() == 0) || (exp_q.size() == 1 && bus.m_ready)});
            check("m_valid", {31'd0, bus.m_valid}, {31'd0, exp_q.size() != 0});
            check("frame_count", {27'd0, frame_count}, exp_fc % 32);
            if (exp_q.size() != 0) begin
                check("m_data", {28'd0, bus.m_data}, exp_q[0].data);
                check("m_tag", {30'd0, bus.m_tag}, exp_q[0].tag);
                check("m_last", {31'd0, bus.m_last}, exp_q[0].last);
                if (bus.m_ready) begin
                    if (exp_q[0].last != 0) exp_fc++;
                    void'(exp_q.pop_front());
                end
            end
            if (bus.s_valid && bus.s_ready) begin
                int a, b, c;
                a = int'(bus.s_lane0);
                b = int'(bus.s_lane1);
                c = int'(bus.s_lane2);
                exp_q.push_back('{a, 0, 0});
                exp_q.push_back('{b, 1, 0});
                exp_q.push_back('{c, 2, 0});
                exp_q.push_back('{(a + b + c) % 16, 3, 1});
            end
        end
    end

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Offer a bundle until taken; returns one step after the accepting edge.
    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        bit got = 0;
        bus.s_valid = 1'b1;
        bus.s_lane0 = a;
        bus.s_lane1 = b;
        bus.s_lane2 = c;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (bus.s_ready) begin
                got = 1;
                break;
            end
        end
        if (!got) check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        bus.s_lane0 = 4'($urandom);
        bus.s_lane1 = 4'($urandom);
        bus.s_lane2 = 4'($urandom);
    endtask

    task automatic wait_frame(output logic [3:0] last_data);
        bit got = 0;
        last_data = '0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (bus.m_valid && bus.m_ready && bus.m_last) begin
                last_data = bus.m_data;
                got = 1;
                break;
            end
        end
        if (!got) check("frame_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] ld;
        int         vcnt;
        int         rcnt;

        bus.s_valid = 1'b0;
        bus.s_lane0 = '0;
        bus.s_lane1 = '0;
        bus.s_lane2 = '0;
        bus.m_ready = 1'b1;
        apply_reset();

        // Reset state
        check("rst_m_valid", {31'd0, bus.m_valid}, 0);
        check("rst_m_data", {28'd0, bus.m_data}, 0);
        check("rst_m_tag", {30'd0, bus.m_tag}, 0);
        check("rst_m_last", {31'd0, bus.m_last}, 0);
        check("rst_fc", {27'd0, frame_count}, 0);
        check("rst_s_ready", {31'd0, bus.s_ready}, 1);

        // Lanes 1/2/3: checksum 6, one frame done
        send(4'h1, 4'h2, 4'h3);
        check("first_beat_tag0", {30'd0, bus.m_tag}, 0);
        check("first_beat_data", {28'd0, bus.m_data}, 1);
        wait_frame(ld);
        check("sum_123", {28'd0, ld}, 6);
        check("fc_after_1", {27'd0, frame_count}, 1);

        // Lanes F/F/F: 45 mod 16 = 0xD
        send(4'hF, 4'hF, 4'hF);
        wait_frame(ld);
        check("sum_fff", {28'd0, ld}, 32'hD);
        check("sum_fff_known", {31'd0, $isunknown(ld)}, 0);

        // Backpressure on the lane1 beat
        send(4'h4, 4'h5, 4'h6);
        @(posedge clk);
        #1;
        bus.m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_tag", {30'd0, bus.m_tag}, 1);
            check("stall_data", {28'd0, bus.m_data}, 5);
            check("stall_s_ready", {31'd0, bus.s_ready}, 0);
        end
        @(posedge clk);
        #1;
        bus.m_ready = 1'b1;
        wait_frame(ld);
        check("sum_456", {28'd0, ld}, 32'hF);

        // Back-to-back bundles with s_valid held high
        bus.s_valid = 1'b1;
        bus.s_lane0 = 4'h7;
        bus.s_lane1 = 4'h8;
        bus.s_lane2 = 4'h9;
        @(negedge clk);
        @(posedge clk);
        #1;
        bus.s_lane0 = 4'hA;
        bus.s_lane1 = 4'hB;
        bus.s_lane2 = 4'hC;
        vcnt = 0;
        rcnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            vcnt += int'(bus.m_valid);
            rcnt += int'(bus.s_ready);
        end
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        wait_frame(ld);
        check("b2b_beats", vcnt, 8);
        check("b2b_ready_pulses", rcnt, 2);
        check("b2b_sum", {28'd0, ld}, 32'h1);

        // Counter wrap: 32 frames back to 0, 33rd to 1
        apply_reset();
        for (int i = 0; i < 32; i++) begin
            send(4'(i), 4'(i + 1), 4'(2 * i));
            wait_frame(ld);
        end
        check("fc_wrap_0", {27'd0, frame_count}, 0);
        send(4'h3, 4'h3, 4'h3);
        wait_frame(ld);
        check("fc_wrap_1", {27'd0, frame_count}, 1);

        // Async reset during SEND1
        apply_reset();
        send(4'h1, 4'h2, 4'h3);
        @(posedge clk);
        #1;
        check("pre_rst_tag", {30'd0, bus.m_tag}, 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_m_valid", {31'd0, bus.m_valid}, 0);
        check("arst_m_data", {28'd0, bus.m_data}, 0);
        check("arst_m_tag", {30'd0, bus.m_tag}, 0);
        check("arst_m_last", {31'd0, bus.m_last}, 0);
        check("arst_fc", {27'd0, frame_count}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_s_ready", {31'd0, bus.s_ready}, 1);
        send(4'h2, 4'h3, 4'h4);
        wait_frame(ld);
        check("post_rst_sum", {28'd0, ld}, 9);
        check("post_rst_fc", {27'd0, frame_count}, 1);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
